// File: rtl/tile_accumulator_pkg.sv
// ============================================================================
// Module   : tile_accumulator_pkg
// Brief    : Shared defaults, state encoding and helpers for tile_accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tile_accumulator_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MAX_LEN_LOG = 7;
    localparam int DEF_NUM_MUL     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_accumulator_priority_grant.sv
// ============================================================================
// Module   : tile_accumulator_priority_grant
// Brief    : Combinational fixed-priority arbiter, lowest unmasked request wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tile_accumulator_priority_grant
    import tile_accumulator_pkg::*;
#(
    parameter int N     = DEF_NUM_MUL,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [N-1:0] eligible;

    always_comb begin
        eligible  = req & ~mask;
        // Two's-complement trick isolates the lowest set bit.
        grant     = eligible & (~eligible + 1'b1);
        grant_any = |eligible;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tile_accumulator.sv
// ============================================================================
// Module   : tile_accumulator
// Brief    : Arbitrates 2x2 partial tiles from NUM_MUL multipliers, sums
//            tile_count of them and holds the result until acknowledged.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tile_accumulator
    import tile_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MAX_LEN_LOG = DEF_MAX_LEN_LOG,
    parameter int NUM_MUL     = DEF_NUM_MUL
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MAX_LEN_LOG-1:0]        tile_count,
    input  logic [NUM_MUL-1:0]            mul_finish,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] mul_c11,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] mul_c12,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] mul_c21,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] mul_c22,
    output logic [NUM_MUL-1:0]            mul_c_ack,
    output logic [DATA_WIDTH-1:0]         acc_c11,
    output logic [DATA_WIDTH-1:0]         acc_c12,
    output logic [DATA_WIDTH-1:0]         acc_c21,
    output logic [DATA_WIDTH-1:0]         acc_c22,
    output logic                          acc_valid,
    input  logic                          acc_ack,
    output logic                          busy
);

    localparam int IDX_W = idx_width(NUM_MUL);
    localparam int LANES = 4;

    state_t                              state_q, state_d;
    logic [MAX_LEN_LOG-1:0]              tile_count_q, tile_count_d;
    logic [MAX_LEN_LOG-1:0]              cnt_q, cnt_d, cnt_inc;
    logic [LANES-1:0][DATA_WIDTH-1:0]    acc_q, acc_d, lane_in;
    logic [NUM_MUL-1:0]                  mul_c_ack_q, mul_c_ack_d;
    logic [NUM_MUL-1:0]                  gnt;
    logic [IDX_W-1:0]                    gnt_idx;
    logic                                gnt_any;
    logic                                load;
    int                                  base;

    // A unit still sees its own ack pulse while finish is high; masking stops a re-grant.
    tile_accumulator_priority_grant #(
        .N     (NUM_MUL),
        .IDX_W (IDX_W)
    ) u_grant (
        .req       (mul_finish),
        .mask      (mul_c_ack_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    always_comb begin
        base       = int'(gnt_idx) * DATA_WIDTH;
        lane_in[0] = mul_c11[base +: DATA_WIDTH];
        lane_in[1] = mul_c12[base +: DATA_WIDTH];
        lane_in[2] = mul_c21[base +: DATA_WIDTH];
        lane_in[3] = mul_c22[base +: DATA_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        tile_count_d = tile_count_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mul_c_ack_d  = '0;
        cnt_inc      = cnt_q + 1'b1;
        load         = start && ((state_q == S_IDLE) || ((state_q == S_HOLD) && acc_ack));

        case (state_q)
            S_ACCUM: begin
                if (gnt_any) begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = acc_q[l] + lane_in[l];
                    end
                    cnt_d       = cnt_inc;
                    mul_c_ack_d = gnt;
                    if (cnt_inc == tile_count_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (acc_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE:  ;
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            tile_count_d = tile_count;
            acc_d        = '0;
            cnt_d        = '0;
            state_d      = (tile_count == '0) ? S_HOLD : S_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tile_count_q <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            mul_c_ack_q  <= '0;
        end else begin
            state_q      <= state_d;
            tile_count_q <= tile_count_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mul_c_ack_q  <= mul_c_ack_d;
        end
    end

    assign mul_c_ack = mul_c_ack_q;
    assign acc_c11   = acc_q[0];
    assign acc_c12   = acc_q[1];
    assign acc_c21   = acc_q[2];
    assign acc_c22   = acc_q[3];
    assign acc_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tile_accumulator.sv
// ============================================================================
// Module   : tb_tile_accumulator
// Brief    : Scoreboard bench: stimulus queues expected tiles/acks, monitor checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tile_accumulator;

    localparam int DW = 32;
    localparam int ML = 7;
    localparam int NM = 3;

    typedef struct packed {
        logic [DW-1:0] c11;
        logic [DW-1:0] c12;
        logic [DW-1:0] c21;
        logic [DW-1:0] c22;
    } tile_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ML-1:0]     tile_count;
    logic [NM-1:0]     mul_finish;
    logic [NM*DW-1:0]  mul_c11, mul_c12, mul_c21, mul_c22;
    logic [NM-1:0]     mul_c_ack;
    logic [DW-1:0]     acc_c11, acc_c12, acc_c21, acc_c22;
    logic              acc_valid;
    logic              acc_ack;
    logic              busy;

    tile_t             exp_tiles[$];
    int                exp_acks[$];
    int                tests = 0;
    int                fails = 0;
    bit                shown = 1'b0;
    int                mon_u;
    logic [NM-1:0]     mon_exp_ack;
    tile_t             mon_exp_t, mon_got_t;

    always #5 clk = ~clk;

    tile_accumulator #(
        .DATA_WIDTH  (DW),
        .MAX_LEN_LOG (ML),
        .NUM_MUL     (NM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tile_count (tile_count),
        .mul_finish (mul_finish),
        .mul_c11    (mul_c11),
        .mul_c12    (mul_c12),
        .mul_c21    (mul_c21),
        .mul_c22    (mul_c22),
        .mul_c_ack  (mul_c_ack),
        .acc_c11    (acc_c11),
        .acc_c12    (acc_c12),
        .acc_c21    (acc_c21),
        .acc_c22    (acc_c22),
        .acc_valid  (acc_valid),
        .acc_ack    (acc_ack),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (mul_c_ack != '0) begin
            tests++;
            if (exp_acks.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: got %b, none expected", mul_c_ack);
            end else begin
                mon_u       = exp_acks.pop_front();
                mon_exp_ack = NM'(1 << mon_u);
                if (mul_c_ack !== mon_exp_ack) begin
                    fails++;
                    $display("FAIL ack_order: got %b, expected %b", mul_c_ack, mon_exp_ack);
                end
            end
        end
        if (acc_valid && !shown) begin
            shown = 1'b1;
            tests++;
            mon_got_t = '{c11: acc_c11, c12: acc_c12, c21: acc_c21, c22: acc_c22};
            if (exp_tiles.size() == 0) begin
                fails++;
                $display("FAIL tile_unexpected: got %h", mon_got_t);
            end else begin
                mon_exp_t = exp_tiles.pop_front();
                if (mon_got_t !== mon_exp_t) begin
                    fails++;
                    $display("FAIL tile_value: got %h, expected %h", mon_got_t, mon_exp_t);
                end
            end
        end
        if (acc_valid && acc_ack) begin
            shown = 1'b0;
        end
    end

    // Multiplier model: a unit drops finish on the edge that samples its ack.
    task automatic tick();
        logic [NM-1:0] snap;
        @(negedge clk);
        snap = mul_c_ack;
        @(posedge clk);
        #1;
        mul_finish = mul_finish & ~snap;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic present(input int u, input logic [DW-1:0] a, b, c, d);
        mul_c11[u*DW +: DW] = a;
        mul_c12[u*DW +: DW] = b;
        mul_c21[u*DW +: DW] = c;
        mul_c22[u*DW +: DW] = d;
        mul_finish[u]       = 1'b1;
    endtask

    task automatic expect_tile(input logic [DW-1:0] a, b, c, d);
        exp_tiles.push_back('{c11: a, c12: b, c21: c, c22: d});
    endtask

    task automatic start_tile(input logic [ML-1:0] tc);
        start      = 1'b1;
        tile_count = tc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!acc_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, acc_valid}, 32'd1);
    endtask

    task automatic ack_tile();
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int n;
        reset      = 1'b0;
        start      = 1'b0;
        tile_count = '0;
        mul_finish = '0;
        mul_c11    = '0;
        mul_c12    = '0;
        mul_c21    = '0;
        mul_c22    = '0;
        acc_ack    = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {29'd0, mul_c_ack}, 32'd0);
        chk("rst_c11", acc_c11, 32'd0);
        reset = 1'b1;
        tick();

        // Single partial tile.
        expect_tile(32'd1, 32'd2, 32'd3, 32'd4);
        exp_acks.push_back(0);
        start_tile(7'd1);
        present(0, 32'd1, 32'd2, 32'd3, 32'd4);
        wait_valid("t1_valid");
        ack_tile();
        chk("t1_valid_clr", {31'd0, acc_valid}, 32'd0);
        chk("t1_busy_clr", {31'd0, busy}, 32'd0);

        // Three units finishing together are served in index order.
        expect_tile(32'd60, 32'd6, 32'hFFFF_FFFD, 32'd600);
        exp_acks.push_back(0);
        exp_acks.push_back(1);
        exp_acks.push_back(2);
        start_tile(7'd3);
        present(0, 32'd10, 32'd1, 32'hFFFF_FFFF, 32'd100);
        present(1, 32'd20, 32'd2, 32'hFFFF_FFFF, 32'd200);
        present(2, 32'd30, 32'd3, 32'hFFFF_FFFF, 32'd300);
        tick();
        chk("t2_ack_t1", {29'd0, mul_c_ack}, 32'd1);
        tick();
        chk("t2_ack_t2", {29'd0, mul_c_ack}, 32'd2);
        chk("t2_not_valid", {31'd0, acc_valid}, 32'd0);
        tick();
        chk("t2_ack_t3", {29'd0, mul_c_ack}, 32'd4);
        chk("t2_valid_t3", {31'd0, acc_valid}, 32'd1);
        ack_tile();

        // Wraparound from a single unit sending twice.
        expect_tile(32'd1, 32'd12, 32'd0, 32'h8000_0000);
        exp_acks.push_back(1);
        exp_acks.push_back(1);
        start_tile(7'd2);
        present(1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF);
        n = 0;
        while (mul_finish[1] && n < 10) begin
            tick();
            n++;
        end
        present(1, 32'd2, 32'd7, 32'h8000_0000, 32'd1);
        wait_valid("t3_valid");
        ack_tile();

        // Pending unit held off during S_HOLD, then back-to-back start.
        expect_tile(32'd11, 32'd12, 32'd13, 32'd14);
        exp_acks.push_back(0);
        start_tile(7'd1);
        present(0, 32'd11, 32'd12, 32'd13, 32'd14);
        wait_valid("t4_valid_a");
        present(2, 32'd21, 32'd22, 32'd23, 32'd24);
        repeat (3) begin
            tick();
            chk("t4_no_ack_hold", {29'd0, mul_c_ack}, 32'd0);
        end
        chk("t4_hold_stable", acc_c11, 32'd11);
        expect_tile(32'd21, 32'd22, 32'd23, 32'd24);
        exp_acks.push_back(2);
        acc_ack    = 1'b1;
        start      = 1'b1;
        tile_count = 7'd1;
        tick();
        acc_ack    = 1'b0;
        start      = 1'b0;
        chk("t4_b2b_busy", {31'd0, busy}, 32'd1);
        chk("t4_b2b_cleared", {31'd0, acc_valid}, 32'd0);
        tick();
        chk("t4_ack_unit2", {29'd0, mul_c_ack}, 32'd4);
        chk("t4_valid_b", {31'd0, acc_valid}, 32'd1);
        ack_tile();

        // Reset in the middle of accumulation discards the tile.
        exp_acks.push_back(0);
        start_tile(7'd3);
        present(0, 32'd5, 32'd5, 32'd5, 32'd5);
        tick();
        chk("t5_ack_before_rst", {29'd0, mul_c_ack}, 32'd1);
        reset = 1'b0;
        tick();
        chk("t5_rst_c11", acc_c11, 32'd0);
        chk("t5_rst_c22", acc_c22, 32'd0);
        chk("t5_rst_valid", {31'd0, acc_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ack", {29'd0, mul_c_ack}, 32'd0);
        reset = 1'b1;
        tick();
        expect_tile(32'd7, 32'd8, 32'd9, 32'd10);
        exp_acks.push_back(1);
        start_tile(7'd1);
        present(1, 32'd7, 32'd8, 32'd9, 32'd10);
        wait_valid("t5_valid_after");
        ack_tile();

        // Zero-length tile goes straight to hold with a zero result.
        expect_tile(32'd0, 32'd0, 32'd0, 32'd0);
        start_tile(7'd0);
        chk("t6_valid", {31'd0, acc_valid}, 32'd1);
        chk("t6_no_ack", {29'd0, mul_c_ack}, 32'd0);
        tick();
        chk("t6_no_ack_later", {29'd0, mul_c_ack}, 32'd0);
        ack_tile();
        chk("t6_busy_clr", {31'd0, busy}, 32'd0);

        n = 0;
        while ((exp_tiles.size() != 0 || exp_acks.size() != 0) && n < 10) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", exp_tiles.size() + exp_acks.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tile_accumulator.md
Name: tile_accumulator

Overview:
- Downstream stage of the 2x2-tile matrix multiplier; takes the place of its adder.
- Collects 2x2 partial-product tiles from NUM_MUL AxA_multiplier units and arbitrates among them.
- Sums tile_count partial tiles per output tile, then holds the finished 2x2 result tile until the result writer acknowledges it.

Parameters:
DATA_WIDTH, 32, width of each matrix element
MAX_LEN_LOG, 7, width of tile_count and internal partial-tile counter
NUM_MUL, 3, number of AxA_multiplier units feeding this block

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse: begin a new output tile
tile_count  input  MAX_LEN_LOG  partial tiles per output tile (ceil(MIDDLE_LEN/2)), sampled on accepted start
mul_finish  input  NUM_MUL  output_Stable of each multiplier, bit i = unit i
mul_c11  input  NUM_MUL*DATA_WIDTH  C11 of each unit, slice i = unit i
mul_c12  input  NUM_MUL*DATA_WIDTH  C12 per unit
mul_c21  input  NUM_MUL*DATA_WIDTH  C21 per unit
mul_c22  input  NUM_MUL*DATA_WIDTH  C22 per unit
mul_c_ack  output  NUM_MUL  input_C_Ack per unit, registered one-cycle pulse
acc_c11  output  DATA_WIDTH  accumulated upper-left
acc_c12  output  DATA_WIDTH  accumulated upper-right
acc_c21  output  DATA_WIDTH  accumulated lower-left
acc_c22  output  DATA_WIDTH  accumulated lower-right
acc_valid  output  1  finished tile present on acc_*
acc_ack  input  1  writer has consumed the tile
busy  output  1  high in S_ACCUM and S_HOLD

Behaviour:
- Reset:
  - Sampled only at posedge with reset==0.
  - state=S_IDLE; all acc_* = 0; acc_valid, busy, mul_c_ack = 0; counter = 0.
  - Applies mid-operation: an in-flight tile is discarded and no ack is issued.
- States:
  - S_IDLE: start=1 latches tile_count, clears acc_* and counter, moves to S_ACCUM.
    - If the latched tile_count is 0, go straight to S_HOLD with zero tile.
  - S_ACCUM: each cycle, eligible[i] = mul_finish[i] & ~mul_c_ack[i].
    - Fixed priority grants the lowest eligible i; at most one grant per cycle.
    - On grant: each acc lane += slice i, counter += 1, mul_c_ack[i]=1 in the next cycle only.
    - When counter+1 == tile_count on a grant, go to S_HOLD.
  - S_HOLD: acc_valid=1; acc_* stable; mul_finish is ignored and pending units stay pending.
    - acc_ack=1 alone: go to S_IDLE, acc_valid=0 next cycle.
    - acc_ack=1 with start=1: go directly to S_ACCUM with cleared accumulators and new tile_count (back-to-back).
- Handshake contract:
  - A unit drops mul_finish on the clock edge that samples its mul_c_ack.
  - Masking by mul_c_ack therefore prevents double-counting.
  - Each accepted tile yields exactly one ack pulse.
- Latency:
  - Grant in cycle t: sum visible at t+1.
  - Final grant in cycle t: acc_valid=1 in cycle t+1.
- Arithmetic: two's-complement add, wrap modulo 2^DATA_WIDTH, no saturation, no flags. Order-independent.
- start outside S_IDLE, or in S_HOLD without acc_ack, is ignored.
- acc_ack outside S_HOLD is ignored.

Decomposition:
- Shared package: state encodings S_IDLE/S_ACCUM/S_HOLD, DATA_WIDTH and MAX_LEN_LOG defaults, NUM_MUL default.
- One sub-module, priority_grant:
  - Inputs: req = mul_finish, mask = mul_c_ack.
  - Outputs: one-hot grant and its index, purely combinational.
- The four adder lanes stay inline.

Test Plan:
- tile_count=1; mul_finish[0]=1 with C=1,2,3,4 -> mul_c_ack[0] pulses one cycle; next cycle acc_valid=1 with acc=1,2,3,4; acc_ack -> acc_valid=0, busy=0.
- tile_count=3; all three units finish same cycle t with C11=10,20,30 -> grants 0,1,2 in t, t+1, t+2; acks in t+1..t+3; acc_c11=60 with acc_valid at t+3.
- tile_count=2; unit 1 sends C11=0xFFFFFFFF, then C11=0x00000002 -> acc_c11=0x00000001.
- In S_HOLD, unit 2 raises finish -> no ack while held; acc_ack+start together, tile_count=1 -> unit 2 acked next cycle, new tile = its data.
- reset=0 mid-S_ACCUM after 1 of 3 tiles -> next cycle all outputs 0, state S_IDLE; a later start accumulates from zero.
- start with tile_count=0 -> acc_valid=1 next cycle with all acc_*=0, no mul_c_ack.
